// File: rtl/interrupt_source_ctrl.sv
// interrupt_source_ctrl: edge-latched, masked, priority interrupt source controller for the RAT CPU
// Ports: CLK clock; RST_N sync active-low reset; IRQ_IN peripheral request lines;
//   IO_STRB/PORT_ID/OUT_PORT CPU output bus; IN_PORT read mux; INT_ACK ISR entry pulse; INTR request to CPU.
// Registers: MASK at ID_MASK (r/w), PEND at ID_PEND (r, write-1-to-clear), CAUSE at ID_CAUSE (r, write = EOI).
// Option: define IRQ_SYNC_EN to add a two-flop synchronizer in front of edge detection.
module interrupt_source_ctrl #(
  parameter int         NUM_SRC  = 8,
  parameter logic [7:0] ID_MASK  = 8'h30,
  parameter logic [7:0] ID_PEND  = 8'h31,
  parameter logic [7:0] ID_CAUSE = 8'h32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic               IO_STRB,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  output logic [7:0]         IN_PORT,
  input  logic               INT_ACK,
  output logic               INTR
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_n;
  logic [NUM_SRC-1:0] irq, irq_prev, irq_edge, mask, pend, pend_clr, req;
  logic cause_vld;
  logic [2:0] cause_idx, win;
  logic wr_mask, wr_pend, ack, eoi;
`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;
  always_ff @(posedge CLK)
    if (!RST_N) {sync2, sync1} <= '0;
    else {sync2, sync1} <= {sync1, IRQ_IN};
  assign irq = sync2;
`else
  assign irq = IRQ_IN;
`endif
  assign irq_edge = irq & ~irq_prev;
  assign req      = pend & mask;
  assign wr_mask  = IO_STRB && PORT_ID == ID_MASK;
  assign wr_pend  = IO_STRB && PORT_ID == ID_PEND;
  assign ack      = INT_ACK && state == REQ;
  assign eoi      = IO_STRB && PORT_ID == ID_CAUSE && state == SERVICE;
  // An edge arriving in the same cycle as its clear must survive, so the OR comes last.
  assign pend_clr = (wr_pend ? OUT_PORT[NUM_SRC-1:0] : '0) | (ack ? (NUM_SRC'(1) << cause_idx) : '0);
  // Descending scan so the lowest pending-and-enabled index is the final assignment.
  always_comb begin
    win = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req[i]) win = 3'(i);
  end
  always_ff @(posedge CLK)
    if (!RST_N) begin
      irq_prev  <= '0;
      mask      <= '0;
      pend      <= '0;
      cause_vld <= 1'b0;
      cause_idx <= 3'd0;
    end else begin
      irq_prev <= irq;
      pend     <= (pend & ~pend_clr) | irq_edge;
      if (wr_mask) mask <= OUT_PORT[NUM_SRC-1:0];
      if (state == IDLE && |req) {cause_vld, cause_idx} <= {1'b1, win};
      else if (eoi) {cause_vld, cause_idx} <= '0;
    end
  always_ff @(posedge CLK)
    if (!RST_N) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE    ? (|req ? REQ : IDLE) :
              state == REQ     ? (INT_ACK ? SERVICE : REQ) :
              state == SERVICE ? (eoi ? IDLE : SERVICE) : IDLE;
  always_comb INTR = state == REQ;
  always_comb
    IN_PORT = PORT_ID == ID_MASK  ? 8'(mask) :
              PORT_ID == ID_PEND  ? 8'(pend) :
              PORT_ID == ID_CAUSE ? {cause_vld, 4'b0000, cause_idx} : 8'h00;
endmodule

// File: tb/tb_interrupt_source_ctrl.sv
// tb_interrupt_source_ctrl: scoreboard bench for interrupt_source_ctrl with directed vectors
module tb_interrupt_source_ctrl;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] IRQ_IN = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] PORT_ID = 8'h00;
  logic [7:0] OUT_PORT = 8'h00;
  logic [7:0] IN_PORT;
  logic       INT_ACK = 1'b0;
  logic       INTR;
  int checks = 0;
  int errors = 0;
  string      q_name[$];
  logic [7:0] q_data[$];
  logic       q_intr[$];
  interrupt_source_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .IRQ_IN(IRQ_IN), .IO_STRB(IO_STRB), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .IN_PORT(IN_PORT), .INT_ACK(INT_ACK), .INTR(INTR)
  );
  always #5 CLK = ~CLK;
  initial begin
    #100000;
    $display("FAIL timeout: run did not reach summary");
    $fatal(1);
  end
  initial forever begin
    @(negedge CLK);
    if (q_name.size() != 0) begin
      string n;
      logic [7:0] d;
      logic i;
      n = q_name.pop_front();
      d = q_data.pop_front();
      i = q_intr.pop_front();
      checks++;
      if (IN_PORT !== d || INTR !== i) begin
        errors++;
        $display("FAIL %s: got IN_PORT=%h INTR=%b, expected IN_PORT=%h INTR=%b", n, IN_PORT, INTR, d, i);
      end
    end
  end
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    IO_STRB = 1'b1;
    PORT_ID = id;
    OUT_PORT = data;
    cyc();
    IO_STRB = 1'b0;
    OUT_PORT = 8'h00;
  endtask
  task automatic ack();
    INT_ACK = 1'b1;
    cyc();
    INT_ACK = 1'b0;
  endtask
  task automatic pulse(input logic [7:0] v);
    IRQ_IN = v;
    cyc();
    IRQ_IN = 8'h00;
  endtask
  task automatic chk(input string n, input logic [7:0] id, input logic [7:0] d, input logic i);
    PORT_ID = id;
    q_name.push_back(n);
    q_data.push_back(d);
    q_intr.push_back(i);
    cyc();
  endtask
  initial begin
    cyc();
    cyc();
    RST_N = 1'b1;
    chk("rst_mask", 8'h30, 8'h00, 1'b0);
    chk("rst_pend", 8'h31, 8'h00, 1'b0);
    chk("rst_cause", 8'h32, 8'h00, 1'b0);
    chk("unmapped_port", 8'h55, 8'h00, 1'b0);
    wr(8'h30, 8'h01);
    chk("mask_rb", 8'h30, 8'h01, 1'b0);
    pulse(8'h01);
    chk("src0_pend", 8'h31, 8'h01, 1'b0);
    chk("src0_req", 8'h32, 8'h80, 1'b1);
    ack();
    chk("src0_ack_pend", 8'h31, 8'h00, 1'b0);
    chk("src0_ack_cause", 8'h32, 8'h80, 1'b0);
    wr(8'h32, 8'h00);
    chk("src0_eoi", 8'h32, 8'h00, 1'b0);
    wr(8'h30, 8'hFF);
    pulse(8'h24);
    chk("dual_pend", 8'h31, 8'h24, 1'b0);
    chk("dual_cause2", 8'h32, 8'h82, 1'b1);
    ack();
    chk("dual_pend_left", 8'h31, 8'h20, 1'b0);
    wr(8'h32, 8'h00);
    chk("dual_eoi", 8'h32, 8'h00, 1'b0);
    chk("dual_cause5", 8'h32, 8'h85, 1'b1);
    ack();
    chk("dual_pend_empty", 8'h31, 8'h00, 1'b0);
    wr(8'h32, 8'h00);
    chk("dual_eoi2", 8'h32, 8'h00, 1'b0);
    wr(8'h30, 8'h00);
    pulse(8'h08);
    chk("masked_pend", 8'h31, 8'h08, 1'b0);
    chk("masked_no_intr", 8'h32, 8'h00, 1'b0);
    wr(8'h30, 8'h08);
    chk("unmask_idle", 8'h32, 8'h00, 1'b0);
    chk("unmask_req", 8'h32, 8'h83, 1'b1);
    ack();
    chk("unmask_ack_pend", 8'h31, 8'h00, 1'b0);
    wr(8'h32, 8'h00);
    wr(8'h30, 8'hFF);
    IRQ_IN = 8'h02;
    cyc();
    chk("hold_idle", 8'h32, 8'h00, 1'b0);
    chk("hold_req", 8'h32, 8'h81, 1'b1);
    ack();
    wr(8'h32, 8'h00);
    chk("hold_no_pend", 8'h31, 8'h00, 1'b0);
    chk("hold_no_req", 8'h32, 8'h00, 1'b0);
    IRQ_IN = 8'h00;
    cyc();
    pulse(8'h02);
    chk("coinc_idle", 8'h32, 8'h00, 1'b0);
    chk("coinc_req", 8'h32, 8'h81, 1'b1);
    IRQ_IN = 8'h02;
    ack();
    IRQ_IN = 8'h00;
    chk("coinc_pend_kept", 8'h31, 8'h02, 1'b0);
    wr(8'h32, 8'h00);
    chk("coinc_eoi", 8'h32, 8'h00, 1'b0);
    chk("coinc_rereq", 8'h32, 8'h81, 1'b1);
    RST_N = 1'b0;
    cyc();
    RST_N = 1'b1;
    chk("rst2_mask", 8'h30, 8'h00, 1'b0);
    chk("rst2_pend", 8'h31, 8'h00, 1'b0);
    chk("rst2_cause", 8'h32, 8'h00, 1'b0);
    ack();
    chk("idle_ack_cause", 8'h32, 8'h00, 1'b0);
    wr(8'h32, 8'h00);
    chk("idle_eoi_cause", 8'h32, 8'h00, 1'b0);
    pulse(8'h01);
    chk("w1c_before", 8'h31, 8'h01, 1'b0);
    wr(8'h31, 8'h01);
    chk("w1c_after", 8'h31, 8'h00, 1'b0);
    for (int k = 0; k < 10 && q_name.size() != 0; k++) cyc();
    if (q_name.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d checks still queued, expected 0", q_name.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/interrupt_source_ctrl.md
# interrupt_source_ctrl

Peripheral-side interrupt controller for the RAT CPU: collects up to eight peripheral interrupt lines, latches rising edges as pending requests, and drives the single INTR request into the CPU core. It holds INTR until the CPU acknowledges entry to its ISR, then waits for an end-of-interrupt write before raising the next request. Mask, pending and cause registers sit on the CPU I/O port bus (PORT_ID / OUT_PORT / IN_PORT, IO_STRB).

## Interface
- NUM_SRC, 8, number of interrupt sources, legal range 1..8
- ID_MASK, 8'h30, port ID of the mask register (read/write)
- ID_PEND, 8'h31, port ID of the pending register (read; write-1-to-clear)
- ID_CAUSE, 8'h32, port ID of the cause register (read; any write = EOI)

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST_N  input  1  synchronous, active-low reset
- IRQ_IN  input  NUM_SRC  peripheral request lines, level, edge-detected internally
- IO_STRB  input  1  CPU output strobe, one cycle per OUT instruction
- PORT_ID  input  8  CPU port address
- OUT_PORT  input  8  CPU output data
- IN_PORT  output  8  read data, combinational mux on PORT_ID
- INT_ACK  input  1  one-cycle pulse from CPU when it vectors to the ISR
- INTR  output  1  interrupt request to CPU

## Operation
- Edge detect: per source, irq_prev register; edge = IRQ_IN[i] & ~irq_prev[i]. Levels held high generate exactly one request.
- PEND[i] set on edge; cleared by ACK of source i or by OUT to ID_PEND with bit i = 1. Set beats clear in the same cycle.
- MASK[i] = 1 enables source i. Masked sources still latch PEND; they request once unmasked.
- Priority: lowest index among PEND & MASK wins.
- FSM states:
  - IDLE: INTR = 0. If (PEND & MASK) != 0: latch winner into CAUSE, go to REQ.
  - REQ: INTR = 1. Committed: mask or pending writes do not withdraw the request. On INT_ACK: clear PEND[CAUSE index], go to SERVICE.
  - SERVICE: INTR = 0. Nested requests are not raised. IO_STRB with PORT_ID = ID_CAUSE (EOI): clear CAUSE valid, go to IDLE.
- CAUSE format: bit7 = valid, bits 2:0 = source index, bits 6:3 = 0.
- IN_PORT mux:
  - ID_MASK: MASK, zero-extended.
  - ID_PEND: PEND, zero-extended.
  - ID_CAUSE: CAUSE.
  - Any other PORT_ID: 8'h00.
- OUT_PORT bits at or above NUM_SRC are ignored.
- Ignored events:
  - INT_ACK outside REQ.
  - EOI outside SERVICE.

## Timing
- Reset (RST_N low at a rising edge) clears, from the next cycle:
  - INTR = 0, FSM = IDLE.
  - MASK = 0, PEND = 0, CAUSE = 8'h00.
  - irq_prev = 0, and synchronizer flops when IRQ_SYNC_EN is defined.
- Reset mid-request drops INTR the cycle after reset is sampled.
- An IRQ_IN already high when reset releases registers as one edge.
- Latency (no sync): IRQ_IN high first sampled at edge k gives PEND visible after k and INTR high after k+1.
- INTR falls the cycle after INT_ACK is sampled.
- From EOI sampled at edge e:
  - FSM is IDLE after e.
  - Next INTR can be high after e+1.
- Register writes take effect after the IO_STRB edge. Reads are same-cycle combinational.

## Configuration
- IRQ_SYNC_EN defined:
  - Each IRQ_IN passes a two-flop synchronizer before edge detect.
  - Adds 2 cycles to request latency.
  - Sources may be asynchronous to CLK.
- IRQ_SYNC_EN undefined:
  - IRQ_IN is used directly.
  - IRQ_IN must be synchronous to CLK.

## Test plan
- Reset, then read ID_MASK, ID_PEND, ID_CAUSE -> all 8'h00; INTR = 0.
- Write MASK = 8'h01; pulse IRQ_IN[0] -> PEND = 8'h01, INTR high 2 cycles after sample. INT_ACK -> INTR = 0, PEND = 8'h00, CAUSE = 8'h80. EOI -> CAUSE = 8'h00.
- MASK = 8'hFF; raise IRQ_IN[5] and IRQ_IN[2] in the same cycle -> CAUSE = 8'h82. After ACK and EOI, second request gives CAUSE = 8'h85.
- MASK = 8'h00; pulse IRQ_IN[3] -> PEND = 8'h08, INTR stays 0. Write MASK = 8'h08 -> INTR rises next cycle.
- Hold IRQ_IN[1] high across ACK of source 1 -> no second request.
- New edge on source 1 coinciding with its ACK -> PEND[1] stays 1.
- Assert RST_N low while in REQ -> INTR = 0 next cycle, all registers cleared.
- INT_ACK in IDLE -> no state change.
